// File: rtl/kd_tree_traverse_pipe.sv
// ============================================================================
// kd_tree_traverse_pipe : pipelined KD-tree descent, one level per stage,
//                         register-held internal nodes, valid/ready flow.
// Option macro: KD_TREE_PATCH_PASSTHRU_EN (carry patch through to out_patch).
// Revision: 1.0
// ============================================================================
`default_nettype none

module kd_tree_traverse_pipe #(
  parameter int DIM_WIDTH = 11,
  parameter int NUM_DIMS  = 5,
  parameter int IDX_WIDTH = 3,
  parameter int DEPTH     = 6,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_restart,
  input  logic                          wr_en,
  input  logic [IDX_WIDTH+DIM_WIDTH-1:0] wr_data,
  output logic                          tree_loaded,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIMS*DIM_WIDTH-1:0] in_patch,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEPTH-1:0]              out_leaf,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [NUM_DIMS*DIM_WIDTH-1:0] out_patch
);

  localparam int NUM_NODES = (1 << DEPTH) - 1;
  localparam int PATCH_W   = NUM_DIMS * DIM_WIDTH;
  localparam int NODE_W    = IDX_WIDTH + DIM_WIDTH;

  function automatic logic [DIM_WIDTH-1:0] pick_comp(
    input logic [PATCH_W-1:0]   patch,
    input logic [IDX_WIDTH-1:0] sel
  );
    // Out-of-range split dimensions fall back to component 0.
    pick_comp = patch[DIM_WIDTH-1:0];
    for (int k = 1; k < NUM_DIMS; k++) begin
      if (sel == IDX_WIDTH'(k)) pick_comp = patch[k*DIM_WIDTH +: DIM_WIDTH];
    end
  endfunction

  // ---------------- node table and write port ----------------
  logic [NODE_W-1:0] node_q [NUM_NODES];
  logic [NODE_W-1:0] node_d [NUM_NODES];
  logic [DEPTH-1:0]  ptr_q, ptr_d;
  logic              loaded_q, loaded_d;

  always_comb begin
    node_d   = node_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    if (wr_restart) begin
      ptr_d    = '0;
      loaded_d = 1'b0;
    end else if (wr_en && !loaded_q) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        if (ptr_q == DEPTH'(i)) node_d[i] = wr_data;
      end
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == DEPTH'(NUM_NODES - 1)) loaded_d = 1'b1;
    end
  end

  // ---------------- lookup pipeline ----------------
  // Stage s holds the pre-lookup in-level index for level s (upper bits zero).
  logic                 advance;
  logic [DEPTH-1:0]     st_valid_q, st_valid_d;
  logic [DEPTH-1:0]     st_idx_q   [DEPTH];
  logic [DEPTH-1:0]     st_idx_d   [DEPTH];
  logic [TAG_WIDTH-1:0] st_tag_q   [DEPTH];
  logic [TAG_WIDTH-1:0] st_tag_d   [DEPTH];
  logic [PATCH_W-1:0]   st_patch_q [DEPTH];
  logic [PATCH_W-1:0]   st_patch_d [DEPTH];
  logic [DEPTH-1:0]     nxt_idx    [DEPTH];

  logic                 out_valid_q, out_valid_d;
  logic [DEPTH-1:0]     out_leaf_q, out_leaf_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

  assign advance = !out_valid_q || out_ready;

  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_level
      logic [DEPTH-1:0]     addr;
      logic [NODE_W-1:0]    word;
      logic [DIM_WIDTH-1:0] comp;
      assign addr       = DEPTH'((1 << s) - 1) + st_idx_q[s];
      assign word       = node_q[addr];
      assign comp       = pick_comp(st_patch_q[s], word[NODE_W-1 -: IDX_WIDTH]);
      assign nxt_idx[s] = {st_idx_q[s][DEPTH-2:0], (comp >= word[DIM_WIDTH-1:0])};
    end
  endgenerate

  always_comb begin
    st_valid_d  = st_valid_q;
    st_idx_d    = st_idx_q;
    st_tag_d    = st_tag_q;
    st_patch_d  = st_patch_q;
    out_valid_d = out_valid_q;
    out_leaf_d  = out_leaf_q;
    out_tag_d   = out_tag_q;
    if (advance) begin
      st_valid_d[0] = in_valid && loaded_q;
      st_idx_d[0]   = '0;
      st_tag_d[0]   = in_tag;
      st_patch_d[0] = in_patch;
      for (int s = 1; s < DEPTH; s++) begin
        st_valid_d[s] = st_valid_q[s-1];
        st_idx_d[s]   = nxt_idx[s-1];
        st_tag_d[s]   = st_tag_q[s-1];
        st_patch_d[s] = st_patch_q[s-1];
      end
      out_valid_d = st_valid_q[DEPTH-1];
      out_leaf_d  = nxt_idx[DEPTH-1];
      out_tag_d   = st_tag_q[DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NODES; i++) node_q[i] <= '0;
      ptr_q      <= '0;
      loaded_q   <= 1'b0;
      st_valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        st_idx_q[s]   <= '0;
        st_tag_q[s]   <= '0;
        st_patch_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      out_leaf_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      node_q      <= node_d;
      ptr_q       <= ptr_d;
      loaded_q    <= loaded_d;
      st_valid_q  <= st_valid_d;
      st_idx_q    <= st_idx_d;
      st_tag_q    <= st_tag_d;
      st_patch_q  <= st_patch_d;
      out_valid_q <= out_valid_d;
      out_leaf_q  <= out_leaf_d;
      out_tag_q   <= out_tag_d;
    end
  end

`ifdef KD_TREE_PATCH_PASSTHRU_EN
  logic [PATCH_W-1:0] out_patch_q, out_patch_d;

  always_comb begin
    out_patch_d = out_patch_q;
    if (advance) out_patch_d = st_patch_q[DEPTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_patch_q <= '0;
    else     out_patch_q <= out_patch_d;
  end

  assign out_patch = out_patch_q;
`else
  assign out_patch = '0;
`endif

  assign tree_loaded = loaded_q;
  assign in_ready    = advance && loaded_q;
  assign out_valid   = out_valid_q;
  assign out_leaf    = out_leaf_q;
  assign out_tag     = out_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_kd_tree_traverse_pipe.sv
// ============================================================================
// tb_kd_tree_traverse_pipe : randomized bench with a recursive-descent
//                            reference model and in-order scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_kd_tree_traverse_pipe;

  localparam int DIM_WIDTH = 11;
  localparam int NUM_DIMS  = 5;
  localparam int IDX_WIDTH = 3;
  localparam int DEPTH     = 6;
  localparam int TAG_WIDTH = 8;
  localparam int PW        = NUM_DIMS * DIM_WIDTH;
  localparam int NW        = IDX_WIDTH + DIM_WIDTH;
  localparam int NN        = (1 << DEPTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_restart = 1'b0;
  logic                 wr_en = 1'b0;
  logic [NW-1:0]        wr_data = '0;
  logic                 tree_loaded;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PW-1:0]        in_patch = '0;
  logic [TAG_WIDTH-1:0] in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DEPTH-1:0]     out_leaf;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [PW-1:0]        out_patch;

  kd_tree_traverse_pipe #(
    .DIM_WIDTH(DIM_WIDTH), .NUM_DIMS(NUM_DIMS), .IDX_WIDTH(IDX_WIDTH),
    .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .wr_restart(wr_restart), .wr_en(wr_en),
    .wr_data(wr_data), .tree_loaded(tree_loaded), .in_valid(in_valid),
    .in_ready(in_ready), .in_patch(in_patch), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf),
    .out_tag(out_tag), .out_patch(out_patch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NW-1:0] tree [NN];
  int            mptr;
  bit            mloaded;

  function automatic int ref_leaf(input logic [PW-1:0] p);
    int n;
    n = 0;
    for (int lvl = 0; lvl < DEPTH; lvl++) begin
      int            d;
      int            m;
      logic [PW-1:0] sh;
      d = int'(tree[n][NW-1:DIM_WIDTH]);
      m = int'(tree[n][DIM_WIDTH-1:0]);
      if (d >= NUM_DIMS) d = 0;
      sh = p >> (d * DIM_WIDTH);
      n  = 2 * n + 1 + ((int'(sh[DIM_WIDTH-1:0]) >= m) ? 1 : 0);
    end
    return n - NN;
  endfunction

  function automatic logic [PW-1:0] rand_patch();
    logic [PW-1:0] p;
    for (int k = 0; k < NUM_DIMS; k++) p[k*DIM_WIDTH +: DIM_WIDTH] = DIM_WIDTH'($urandom_range(0, 2047));
    return p;
  endfunction

  function automatic logic [NW-1:0] rand_node();
    return {IDX_WIDTH'($urandom_range(0, 7)), DIM_WIDTH'($urandom_range(0, 2047))};
  endfunction

  function automatic logic [PW-1:0] exp_out_patch(input logic [PW-1:0] p);
`ifdef KD_TREE_PATCH_PASSTHRU_EN
    return p;
`else
    return (p & '0);
`endif
  endfunction

  // ---------------- scoreboard ----------------
  int                   exp_leaf_q  [$];
  logic [TAG_WIDTH-1:0] exp_tag_q   [$];
  logic [PW-1:0]        exp_patch_q [$];
  logic                 hold_v = 1'b0;
  logic [DEPTH-1:0]     hold_leaf;
  logic [TAG_WIDTH-1:0] hold_tag;
  logic [PW-1:0]        hold_patch;
  int                   n_ret = 0;

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic step(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (hold_v) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_leaf", out_leaf, hold_leaf);
      check_eq("stall_tag", out_tag, hold_tag);
      check_eq("stall_patch", out_patch, hold_patch);
    end
    if (out_valid && out_ready) begin
      if (exp_leaf_q.size() == 0) check_eq("unexpected_out_valid", out_valid, 1'b0);
      else begin
        check_eq("leaf", out_leaf, exp_leaf_q.pop_front());
        check_eq("tag", out_tag, exp_tag_q.pop_front());
        check_eq("patch", out_patch, exp_patch_q.pop_front());
        n_ret++;
      end
    end
    hold_v     = out_valid && !out_ready;
    hold_leaf  = out_leaf;
    hold_tag   = out_tag;
    hold_patch = out_patch;
    if (acc) begin
      exp_leaf_q.push_back(ref_leaf(in_patch));
      exp_tag_q.push_back(in_tag);
      exp_patch_q.push_back(exp_out_patch(in_patch));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_node(input logic [NW-1:0] w);
    bit acc;
    if (!mloaded) begin
      tree[mptr] = w;
      mptr++;
      if (mptr == NN) mloaded = 1'b1;
    end
    wr_en   = 1'b1;
    wr_data = w;
    step(acc);
    wr_en   = 1'b0;
  endtask

  task automatic restart();
    bit acc;
    wr_restart = 1'b1;
    mptr       = 0;
    mloaded    = 1'b0;
    step(acc);
    wr_restart = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < NN; i++) write_node(rand_node());
  endtask

  task automatic stream(input int n, input int ready_pct);
    bit acc;
    int sent;
    int guard;
    sent     = 0;
    guard    = 0;
    in_valid = 1'b1;
    in_patch = rand_patch();
    in_tag   = '0;
    while (sent < n && guard < 2000) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      step(acc);
      if (acc) begin
        sent++;
        in_patch = rand_patch();
        in_tag   = TAG_WIDTH'(sent);
      end
      guard++;
    end
    in_valid = 1'b0;
    check_eq("send_count", sent, n);
  endtask

  task automatic drain();
    bit acc;
    int cyc;
    cyc = 0;
    in_valid = 1'b0;
    while (exp_leaf_q.size() > 0 && cyc < 400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      cyc++;
    end
    out_ready = 1'b1;
    check_eq("drain_pending", exp_leaf_q.size(), 0);
  endtask

  task automatic one_query(input string name, input logic [PW-1:0] p, input int exp_leaf);
    bit acc;
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_patch  = p;
    in_tag    = TAG_WIDTH'($urandom_range(0, 255));
    step(acc);
    in_valid  = 1'b0;
    check_eq({name, "_accept"}, acc, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step(acc);
      lat++;
    end
    check_eq({name, "_latency"}, lat, DEPTH);
    check_eq({name, "_leaf"}, out_leaf, exp_leaf);
    step(acc);
  endtask

  function automatic logic [PW-1:0] patch_with(input int dim, input int val, input logic [PW-1:0] base);
    logic [PW-1:0] p;
    p = base;
    p[dim*DIM_WIDTH +: DIM_WIDTH] = DIM_WIDTH'(val);
    return p;
  endfunction

  initial begin
    bit            acc;
    logic [PW-1:0] p;
    for (int i = 0; i < NN; i++) tree[i] = '0;
    mptr    = 0;
    mloaded = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_leaf", out_leaf, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_out_patch", out_patch, 0);
    check_eq("rst_tree_loaded", tree_loaded, 0);
    rst = 1'b0;
    @(negedge clk);

    // Load: 63 writes, then surplus writes must be ignored
    for (int i = 0; i < NN; i++) begin
      if (i == NN - 1) begin
        check_eq("load_in_ready_early", in_ready, 0);
        check_eq("load_loaded_early", tree_loaded, 0);
      end
      write_node(rand_node());
    end
    check_eq("load_loaded", tree_loaded, 1);
    check_eq("load_in_ready", in_ready, 1);
    write_node(rand_node());
    write_node(rand_node());
    stream(40, 100);
    drain();

    // Single lookup: all nodes {dim 0, median 100}
    restart();
    check_eq("restart_in_ready", in_ready, 0);
    for (int i = 0; i < NN; i++) write_node({IDX_WIDTH'(0), DIM_WIDTH'(100)});
    one_query("single_hi", patch_with(0, 100, rand_patch()), 63);
    one_query("single_lo", patch_with(0, 99, rand_patch()), 0);

    // Dimension select: root {3,50}, others {0,2047}
    restart();
    write_node({IDX_WIDTH'(3), DIM_WIDTH'(50)});
    for (int i = 1; i < NN; i++) write_node({IDX_WIDTH'(0), DIM_WIDTH'(2047)});
    p = patch_with(0, 0, rand_patch());
    one_query("dim_right", patch_with(3, 60, p), 32);
    one_query("dim_left", patch_with(3, 40, p), 0);

    // Streaming with backpressure, tags 0..19, restart while in flight
    restart();
    load_random();
    n_ret = 0;
    stream(20, 50);
    restart();
    check_eq("inflight_restart_in_ready", in_ready, 0);
    drain();
    check_eq("stream_retired", n_ret, 20);

    // Restart priority over a same-cycle write, mid-load
    for (int i = 0; i < 10; i++) write_node(rand_node());
    wr_restart = 1'b1;
    wr_en      = 1'b1;
    wr_data    = rand_node();
    mptr       = 0;
    mloaded    = 1'b0;
    step(acc);
    wr_restart = 1'b0;
    wr_en      = 1'b0;
    check_eq("prio_loaded", tree_loaded, 0);
    check_eq("prio_in_ready", in_ready, 0);
    for (int i = 0; i < NN; i++) begin
      if (i == NN - 1) check_eq("prio_loaded_early", tree_loaded, 0);
      write_node(rand_node());
    end
    check_eq("prio_reloaded", tree_loaded, 1);
    stream(30, 70);
    drain();

    // Async reset mid-stream, between clock edges
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_patch = rand_patch();
      in_tag   = TAG_WIDTH'(i);
      step(acc);
    end
    in_valid = 1'b0;
    check_eq("pre_reset_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_out_valid", out_valid, 0);
    check_eq("async_tree_loaded", tree_loaded, 0);
    check_eq("async_in_ready", in_ready, 0);
    exp_leaf_q.delete();
    exp_tag_q.delete();
    exp_patch_q.delete();
    hold_v = 1'b0;
    for (int i = 0; i < NN; i++) tree[i] = '0;
    mptr    = 0;
    mloaded = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_random();
    p = rand_patch();
    one_query("post_reset", p, ref_leaf(p));
    stream(20, 80);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
